write_pointer_ctrl: RTL and testbench

Write-domain pointer and flag controller for the async FIFO, directly upstream of the read-side pointer logic.
- Owns the binary and Gray write pointers.
- Drives the dual-port memory write enable and address.
- Synchronises the Gray read pointer into wr_clk and converts it to binary.
- Produces full, almost_full, fill level and a sticky overflow flag.
- Its g_wr_ptr output feeds the read-domain pointer block.

---
 rtl/write_pointer_ctrl.sv | 86 ++++++++
 tb/tb_write_pointer_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/write_pointer_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: binary and Gray write
// pointers, read-pointer synchroniser, level/full/almost_full and sticky overflow.
module write_pointer_ctrl #(
  parameter int DEPTH       = 128,
  parameter int PTR_SIZE    = $clog2(DEPTH),
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = DEPTH - 4
) (
  input  logic                wr_clk,
  input  logic                wr_reset_n,
  input  logic                wr_en,
  input  logic [PTR_SIZE:0]   g_rd_ptr,
  input  logic                ovf_clr,
  output logic                mem_we,
  output logic [PTR_SIZE-1:0] mem_waddr,
  output logic [PTR_SIZE:0]   b_wr_ptr,
  output logic [PTR_SIZE:0]   g_wr_ptr,
  output logic                full,
  output logic                almost_full,
  output logic [PTR_SIZE:0]   wr_level,
  output logic                overflow
);

  localparam logic [PTR_SIZE:0] DEPTH_L = (PTR_SIZE+1)'(DEPTH);
  localparam logic [PTR_SIZE:0] AF_L    = (PTR_SIZE+1)'(AF_THRESH);
  localparam logic [PTR_SIZE:0] ONE_L   = (PTR_SIZE+1)'(1);

  logic [PTR_SIZE:0] g_rd_sync_q [SYNC_STAGES];
  logic [PTR_SIZE:0] g_rd_sync;
  logic [PTR_SIZE:0] b_rd_sync;
  logic [PTR_SIZE:0] b_wr_next;
  logic [PTR_SIZE:0] g_wr_next;
  logic              accept;

  // Plain flop chain: nothing may sit between stages or metastability filtering suffers.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) g_rd_sync_q[i] <= '0;
    end else begin
      g_rd_sync_q[0] <= g_rd_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) g_rd_sync_q[i] <= g_rd_sync_q[i-1];
    end
  end

  assign g_rd_sync = g_rd_sync_q[SYNC_STAGES-1];

  always_comb begin
    b_rd_sync = '0;
    b_rd_sync[PTR_SIZE] = g_rd_sync[PTR_SIZE];
    for (int i = PTR_SIZE - 1; i >= 0; i--) b_rd_sync[i] = b_rd_sync[i+1] ^ g_rd_sync[i];
  end

  assign wr_level    = b_wr_ptr - b_rd_sync;
  assign full        = (wr_level == DEPTH_L);
  assign almost_full = (wr_level >= AF_L);

  // Write enable is also held low while reset is asserted so no stray write reaches the RAM.
  assign accept    = wr_en && !full;
  assign mem_we    = accept && wr_reset_n;
  assign mem_waddr = b_wr_ptr[PTR_SIZE-1:0];

  assign b_wr_next = b_wr_ptr + ONE_L;
  assign g_wr_next = b_wr_next ^ (b_wr_next >> 1);

  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      b_wr_ptr <= '0;
      g_wr_ptr <= '0;
    end else if (accept) begin
      b_wr_ptr <= b_wr_next;
      g_wr_ptr <= g_wr_next;
    end
  end

  // A new overflow event takes priority over a same-cycle clear.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_pointer_ctrl.sv
// Self-checking bench for write_pointer_ctrl (DEPTH=8, SYNC_STAGES=2, AF_THRESH=4):
// constant vector table, directed corner sequences and random traffic vs a count-based model.
module tb_write_pointer_ctrl;

  localparam int DEPTH = 8;
  localparam int PS    = 3;
  localparam int SYNC  = 2;
  localparam int AF    = 4;

  logic          wr_clk     = 1'b0;
  logic          wr_reset_n = 1'b0;
  logic          wr_en      = 1'b0;
  logic          ovf_clr    = 1'b0;
  logic [PS:0]   g_rd_ptr   = '0;
  logic          mem_we;
  logic [PS-1:0] mem_waddr;
  logic [PS:0]   b_wr_ptr;
  logic [PS:0]   g_wr_ptr;
  logic          full;
  logic          almost_full;
  logic [PS:0]   wr_level;
  logic          overflow;

  write_pointer_ctrl #(
    .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .AF_THRESH(AF)
  ) dut (
    .wr_clk(wr_clk), .wr_reset_n(wr_reset_n), .wr_en(wr_en), .g_rd_ptr(g_rd_ptr),
    .ovf_clr(ovf_clr), .mem_we(mem_we), .mem_waddr(mem_waddr), .b_wr_ptr(b_wr_ptr),
    .g_wr_ptr(g_wr_ptr), .full(full), .almost_full(almost_full), .wr_level(wr_level),
    .overflow(overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: unbounded counts of accepted writes and of read-pointer value, plus a delay line.
  int m_wr;
  int m_rd;
  int m_sync [SYNC];
  bit m_ovf;
  bit m_full;
  bit m_we_in;
  bit m_clr_in;

  typedef struct {
    logic we;
    logic clr;
    logic e_we;
    int   e_addr;
    int   e_lvl;
    logic e_full;
    logic e_af;
    logic e_ovf;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [PS:0] gray(input int v);
    logic [31:0] t;
    logic [PS:0] b;
    t = v;
    b = t[PS:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr  = 0;
    m_rd  = 0;
    m_ovf = 0;
    for (int i = 0; i < SYNC; i++) m_sync[i] = 0;
  endtask

  task automatic drive_check(input logic we, input logic clr, input int rd);
    int lvl;
    wr_en    = we;
    ovf_clr  = clr;
    m_rd     = rd;
    g_rd_ptr = gray(rd);
    #1;
    lvl      = m_wr - m_sync[SYNC-1];
    m_full   = (lvl == DEPTH);
    m_we_in  = we;
    m_clr_in = clr;
    chk("wr_level",    wr_level,    lvl);
    chk("full",        full,        m_full);
    chk("almost_full", almost_full, lvl >= AF);
    chk("mem_we",      mem_we,      we && !m_full);
    chk("mem_waddr",   mem_waddr,   m_wr % DEPTH);
    chk("b_wr_ptr",    b_wr_ptr,    m_wr % (2 * DEPTH));
    chk("g_wr_ptr",    g_wr_ptr,    gray(m_wr));
    chk("overflow",    overflow,    m_ovf);
  endtask

  task automatic clock();
    @(posedge wr_clk);
    if (m_we_in && !m_full) m_wr++;
    if (m_we_in && m_full) m_ovf = 1;
    else if (m_clr_in)     m_ovf = 0;
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = m_rd;
    @(negedge wr_clk);
  endtask

  task automatic step(input logic we, input logic clr, input int rd);
    drive_check(we, clr, rd);
    clock();
  endtask

  initial begin
    logic [PS:0] g_prev;
    logic [PS:0] b_prev;
    logic [PS-1:0] a_prev;
    int rolls;
    int wraps;
    int rd;

    //               we clr e_we addr lvl full af ovf
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 3, 3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 4, 4, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 5, 5, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 6, 6, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 7, 7, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 0, 8, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 0, 8, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 0, 8, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 8, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 0, 8, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 0, 8, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 0, 8, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 0, 8, 1'b1, 1'b1, 1'b0};

    model_reset();
    repeat (2) @(negedge wr_clk);
    wr_reset_n = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    // Asynchronous reset in the low phase with a write pending.
    #2;
    wr_en      = 1'b1;
    wr_reset_n = 1'b0;
    #1;
    chk("rst_b_wr_ptr", b_wr_ptr, 0);
    chk("rst_g_wr_ptr", g_wr_ptr, 0);
    chk("rst_level",    wr_level, 0);
    chk("rst_full",     full,     0);
    chk("rst_mem_we",   mem_we,   0);
    chk("rst_overflow", overflow, 0);
    model_reset();
    @(negedge wr_clk);
    wr_en = 1'b0;
    @(negedge wr_clk);
    wr_reset_n = 1'b1;

    // Fill, reject, overflow set/clear and precedence.
    for (int i = 0; i < 16; i++) begin
      drive_check(tbl[i].we, tbl[i].clr, 0);
      chk("tbl_mem_we",   mem_we,      tbl[i].e_we);
      chk("tbl_waddr",    mem_waddr,   tbl[i].e_addr);
      chk("tbl_level",    wr_level,    tbl[i].e_lvl);
      chk("tbl_full",     full,        tbl[i].e_full);
      chk("tbl_af",       almost_full, tbl[i].e_af);
      chk("tbl_overflow", overflow,    tbl[i].e_ovf);
      clock();
    end

    // Synchroniser latency from full.
    drive_check(1'b0, 1'b0, 1);
    chk("lat_full_e0", full, 1);
    clock();
    drive_check(1'b0, 1'b0, 1);
    chk("lat_full_e1", full, 1);
    clock();
    drive_check(1'b0, 1'b0, 1);
    chk("lat_full_e2", full, 0);
    chk("lat_level_e2", wr_level, 7);
    clock();

    // almost_full falls as synced level drops from 4 to 3.
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 4);
    drive_check(1'b0, 1'b0, 4);
    chk("af_at_4", almost_full, 1);
    chk("lvl_at_4", wr_level, 4);
    clock();
    step(1'b0, 1'b0, 5);
    step(1'b0, 1'b0, 5);
    drive_check(1'b0, 1'b0, 5);
    chk("af_at_3", almost_full, 0);
    chk("lvl_at_3", wr_level, 3);
    clock();

    // Wrap-around streaming with reader two writes behind.
    rolls = 0;
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      g_prev = g_wr_ptr;
      b_prev = b_wr_ptr;
      a_prev = mem_waddr;
      rd = (m_wr - 2 > m_rd) ? m_wr - 2 : m_rd;
      step(1'b1, 1'b0, rd);
      chk("wrap_gray_1bit", $countones(g_wr_ptr ^ g_prev), 1);
      chk("wrap_full", full, 0);
      if (b_prev == 4'd15 && b_wr_ptr == 4'd0) rolls++;
      if (a_prev == 3'd7 && mem_waddr == 3'd0) wraps++;
    end
    chk("wrap_b_rolls", rolls, 3);
    chk("wrap_addr_wraps", wraps, 5);
    chk("wrap_overflow", overflow, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rd = m_rd;
      if (m_rd < m_wr && $urandom_range(1, 0) == 1) rd = m_rd + 1;
      step(($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0,
           ($urandom_range(9, 0) == 0) ? 1'b1 : 1'b0, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
